// File: rtl/systolic_feeder_pkg.sv
// Shared configuration for the systolic array feeder: array geometry, datapath
// widths, counter sizing and the two FSM state types.
package systolic_feeder_pkg;

  localparam int unsigned sys_rows     = 4;
  localparam int unsigned sys_cols     = 2;
  localparam int unsigned A_BITWIDTH   = 8;
  localparam int unsigned W_BITWIDTH   = 8;
  localparam int unsigned P_BITWIDTH   = 32;
  localparam int unsigned DRAIN_CYCLES = sys_rows + sys_cols;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BEAT_W  = cnt_width(sys_rows);
  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_FULL = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } s_state_e;

  typedef logic [sys_cols-1:0][W_BITWIDTH-1:0] wrow_t;
  typedef logic [sys_rows-1:0][A_BITWIDTH-1:0] avec_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Weight/activation handshakes and array drive bundle of the systolic feeder.
interface systolic_feeder_if;
  import systolic_feeder_pkg::*;

  logic                  w_valid;
  logic                  w_ready;
  wrow_t                 w_data;
  logic                  a_valid;
  logic                  a_ready;
  avec_t                 a_data;
  logic                  a_last;
  logic [P_BITWIDTH-1:0] bias_in;
  logic                  switch;
  logic [sys_cols-1:0]   wfetch;
  wrow_t                 i_wdata;
  logic [sys_rows-1:0]   if_en;
  avec_t                 if_data;
  logic [P_BITWIDTH-1:0] bias;
  logic                  busy;
  logic                  done;

  modport slave (
    input  w_valid, w_data, a_valid, a_data, a_last, bias_in,
    output w_ready, a_ready, switch, wfetch, i_wdata, if_en, if_data, bias, busy, done
  );

  modport master (
    output w_valid, w_data, a_valid, a_data, a_last, bias_in,
    input  w_ready, a_ready, switch, wfetch, i_wdata, if_en, if_data, bias, busy, done
  );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Registered valid+data delay line; one instance per array row provides the
// diagonal input skew.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: double-buffered weight loading FSM plus a tile stream
// FSM that switches weights, skews activations and drains the array.
module systolic_feeder
  import systolic_feeder_pkg::*;
(
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  w_state_e              r_wstate;
  s_state_e              r_sstate;
  logic [BEAT_W-1:0]     r_wcnt;
  logic [DRAIN_W-1:0]    r_dcnt;
  logic [sys_cols-1:0]   r_wfetch;
  wrow_t                 r_wdata;
  logic [P_BITWIDTH-1:0] r_bias;
  logic                  r_done;

  logic                  w_wready;
  logic                  w_aready;
  logic                  w_wacc;
  logic                  w_aacc;
  logic [sys_rows-1:0]   w_if_en;
  avec_t                 w_if_data;

  assign w_wready = (r_wstate != W_FULL);
  assign w_aready = (r_sstate == S_STREAM);
  assign w_wacc   = bus.w_valid & w_wready;
  assign w_aacc   = bus.a_valid & w_aready;

  // Weight loader: rows arrive bottom row first; the buffer stays full until
  // the stream FSM consumes it with a switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wfetch <= '0;
      r_wdata  <= '0;
    end else begin
      r_wfetch <= w_wacc ? '1 : '0;
      if (w_wacc) begin
        r_wdata <= bus.w_data;
      end
      case (r_wstate)
        W_IDLE, W_LOAD: begin
          if (w_wacc) begin
            if (r_wcnt == BEAT_W'(sys_rows - 1)) begin
              r_wcnt   <= '0;
              r_wstate <= W_FULL;
            end else begin
              r_wcnt   <= r_wcnt + BEAT_W'(1);
              r_wstate <= W_LOAD;
            end
          end
        end
        W_FULL: begin
          if (r_sstate == S_SWITCH) begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sstate <= S_IDLE;
      r_dcnt   <= '0;
      r_bias   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_sstate)
        S_IDLE: begin
          if (r_wstate == W_FULL) begin
            r_sstate <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          r_bias   <= bus.bias_in;
          r_sstate <= S_STREAM;
        end
        S_STREAM: begin
          if (w_aacc && bus.a_last) begin
            r_dcnt   <= '0;
            r_sstate <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            r_done   <= 1'b1;
            r_sstate <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt + DRAIN_W'(1);
          end
        end
        default: r_sstate <= S_IDLE;
      endcase
    end
  end

  // Row r sees the accepted vector r+1 cycles later.
  for (genvar r = 0; r < sys_rows; r++) begin : g_skew
    skew_line #(
      .DEPTH (r + 1),
      .WIDTH (A_BITWIDTH)
    ) u_skew (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_aacc),
      .i_data  (bus.a_data[r]),
      .o_valid (w_if_en[r]),
      .o_data  (w_if_data[r])
    );
  end

  assign bus.w_ready = w_wready;
  assign bus.a_ready = w_aready;
  assign bus.switch  = (r_sstate == S_SWITCH);
  assign bus.wfetch  = r_wfetch;
  assign bus.i_wdata = r_wdata;
  assign bus.if_en   = w_if_en;
  assign bus.if_data = w_if_data;
  assign bus.bias    = r_bias;
  assign bus.busy    = (r_sstate != S_IDLE);
  assign bus.done    = r_done;

endmodule
